// File: rtl/fifo8b_defs.sv
// Shared sizing constants for the byte FIFO, the downstream bus buffer
// stage and the FIFO testbench. Kept as plain macros so any consumer can
// pick them up with a quoted include.
`ifndef FIFO8B_DEFS_SV
`define FIFO8B_DEFS_SV

`define FIFO8B_WIDTH 8
`define FIFO8B_DEPTH 4
`define FIFO8B_AW    2

`endif

// File: rtl/regfile8b_x4.sv
// Storage array for the byte FIFO: DEPTH x WIDTH registers with one
// synchronous write port and one combinational read port. The array is
// deliberately not reset, so stale bytes may remain after a FIFO reset;
// the FIFO pointers make them unreachable.
`ifndef FIFO8B_DEFS_SV
`include "fifo8b_defs.sv"
`endif

module regfile8b_x4 #(
   parameter int WIDTH = `FIFO8B_WIDTH,
   parameter int DEPTH = `FIFO8B_DEPTH,
   parameter int AW    = `FIFO8B_AW
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Capture the write data into the addressed entry whenever the FIFO
   // control has accepted a write this cycle.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // The read side is a plain mux; the FIFO registers the selected byte
   // into its own output register, so no extra stage is needed here.
   always_comb begin
      o_rdata = r_mem[i_raddr];
   end

endmodule

// File: rtl/fifo8b_q.sv
// Byte-wide synchronous FIFO that decouples a byte producer from the bus
// buffer stage it feeds. Occupancy is tracked in a registered counter that
// also serves as the control state: 0 is EMPTY, DEPTH is FULL, anything in
// between is PARTIAL. Overflow and underflow attempts are latched into
// sticky flags that only a reset clears.
`ifndef FIFO8B_DEFS_SV
`include "fifo8b_defs.sv"
`endif

module fifo8b_q #(
   parameter int WIDTH = `FIFO8B_WIDTH,
   parameter int DEPTH = `FIFO8B_DEPTH,
   parameter int AW    = `FIFO8B_AW
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] I,
   input  logic             WR_EN,
   output logic             FULL,
   input  logic             RD_EN,
   output logic [WIDTH-1:0] O,
   output logic             O_VALID,
   output logic             EMPTY,
   output logic [AW:0]      COUNT,
   output logic             OVF,
   output logic             UNF
);

   // Names for the three occupancy regions the counter moves through.
   localparam logic [AW:0] ST_EMPTY = '0;
   localparam logic [AW:0] ST_FULL  = (AW+1)'(DEPTH);

   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_o;
   logic             r_oValid;
   logic             r_ovf;
   logic             r_unf;

   logic             w_wrOk;
   logic             w_rdOk;
   logic             w_memWe;
   logic [WIDTH-1:0] w_rdata;

   // Flags come straight from the registered count, and a transfer is
   // only accepted when the relevant flag allows it. A write while FULL is
   // refused even if a read is draining a slot in the same cycle.
   always_comb begin
      EMPTY   = (r_count == ST_EMPTY);
      FULL    = (r_count == ST_FULL);
      w_wrOk  = WR_EN & ~FULL;
      w_rdOk  = RD_EN & ~EMPTY;
      w_memWe = w_wrOk & RST_N;
      COUNT   = r_count;
      O       = r_o;
      O_VALID = r_oValid;
      OVF     = r_ovf;
      UNF     = r_unf;
   end

   regfile8b_x4 #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .i_clk   (CLK),
      .i_we    (w_memWe),
      .i_waddr (r_wp),
      .i_wdata (I),
      .i_raddr (r_rp),
      .o_rdata (w_rdata)
   );

   // Pointer and occupancy bookkeeping. Pointers wrap naturally because
   // they are exactly log2(DEPTH) bits wide. A simultaneous accepted write
   // and read leaves the count untouched while both pointers advance.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= ST_EMPTY;
      end else begin
         if (w_wrOk) begin
            r_wp <= r_wp + AW'(1);
         end
         if (w_rdOk) begin
            r_rp <= r_rp + AW'(1);
         end
         case ({w_wrOk, w_rdOk})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered read data. O only changes on an accepted read, so the
   // downstream buffer sees a stable byte between reads, and O_VALID marks
   // exactly the cycle in which a new byte appeared.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_o      <= '0;
         r_oValid <= 1'b0;
      end else begin
         r_oValid <= w_rdOk;
         if (w_rdOk) begin
            r_o <= w_rdata;
         end
      end
   end

   // Sticky error flags: any refused write or read attempt sets them, and
   // only a reset brings them back down.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (WR_EN && FULL) begin
            r_ovf <= 1'b1;
         end
         if (RD_EN && EMPTY) begin
            r_unf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo8b_q.sv
// Self-checking bench for the byte FIFO: a table of per-cycle vectors for
// the fill/drain/overflow/underflow path, then hand-written sequences for
// sticky underflow, pointer wrap under simultaneous transfers and a
// mid-operation reset.
`ifndef FIFO8B_DEFS_SV
`include "fifo8b_defs.sv"
`endif

module tb_fifo8b_q;

   localparam int W  = `FIFO8B_WIDTH;
   localparam int AW = `FIFO8B_AW;

   logic          CLK;
   logic          RST_N;
   logic [W-1:0]  I;
   logic          WR_EN;
   logic          FULL;
   logic          RD_EN;
   logic [W-1:0]  O;
   logic          O_VALID;
   logic          EMPTY;
   logic [AW:0]   COUNT;
   logic          OVF;
   logic          UNF;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic         rstN;
      logic         wr;
      logic         rd;
      logic [W-1:0] din;
      logic [W-1:0] expO;
      logic         expValid;
      logic [AW:0]  expCount;
      logic         expEmpty;
      logic         expFull;
      logic         expOvf;
      logic         expUnf;
   } vec_t;

   vec_t vecs [11];

   fifo8b_q #(
      .WIDTH (`FIFO8B_WIDTH),
      .DEPTH (`FIFO8B_DEPTH),
      .AW    (`FIFO8B_AW)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .I       (I),
      .WR_EN   (WR_EN),
      .FULL    (FULL),
      .RD_EN   (RD_EN),
      .O       (O),
      .O_VALID (O_VALID),
      .EMPTY   (EMPTY),
      .COUNT   (COUNT),
      .OVF     (OVF),
      .UNF     (UNF)
   );

   // Free-running 100 MHz clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Drive one cycle of inputs, let the edge happen, then settle 1 ns so
   // outputs are sampled away from the edge.
   task automatic applyStimulus(input logic rstN, input logic wr,
                                input logic rd, input logic [W-1:0] din);
      RST_N = rstN;
      WR_EN = wr;
      RD_EN = rd;
      I     = din;
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, got, exp, $time);
      end
   endtask

   task automatic checkAll(input string tag, input logic [W-1:0] expO,
                           input logic expValid, input logic [AW:0] expCount,
                           input logic expEmpty, input logic expFull,
                           input logic expOvf, input logic expUnf);
      checkOutput({tag, ".O"},       32'(O),       32'(expO));
      checkOutput({tag, ".O_VALID"}, 32'(O_VALID), 32'(expValid));
      checkOutput({tag, ".COUNT"},   32'(COUNT),   32'(expCount));
      checkOutput({tag, ".EMPTY"},   32'(EMPTY),   32'(expEmpty));
      checkOutput({tag, ".FULL"},    32'(FULL),    32'(expFull));
      checkOutput({tag, ".OVF"},     32'(OVF),     32'(expOvf));
      checkOutput({tag, ".UNF"},     32'(UNF),     32'(expUnf));
   endtask

   initial begin
      logic [W-1:0] expQ [$];
      logic [W-1:0] lastO;

      RST_N = 1'b0;
      WR_EN = 1'b0;
      RD_EN = 1'b0;
      I     = '0;

      // Reset with a write pending, fill, overflow with a read, drain,
      // then underflow.
      //            rstN wr   rd   din    O      vld  cnt   E    F    ovf  unf
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h55, 8'h11, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h22, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h44, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h44, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h44, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1};

      $display("[TB] table-driven fill/drain/overflow/underflow");
      for (int v = 0; v < 11; v++) begin
         applyStimulus(vecs[v].rstN, vecs[v].wr, vecs[v].rd, vecs[v].din);
         checkAll($sformatf("vec%0d", v), vecs[v].expO, vecs[v].expValid,
                  vecs[v].expCount, vecs[v].expEmpty, vecs[v].expFull,
                  vecs[v].expOvf, vecs[v].expUnf);
      end

      // UNF must stay set with the FIFO idle, and O must hold.
      $display("[TB] sticky underflow");
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      end
      checkAll("sticky", 8'h44, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);

      // Preload two bytes, then six simultaneous write/read cycles that
      // walk the write pointer across the 3->0 boundary, then drain.
      $display("[TB] pointer wrap with simultaneous transfers");
      applyStimulus(1'b1, 1'b1, 1'b0, 8'hB0);
      expQ.push_back(8'hB0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'hB1);
      expQ.push_back(8'hB1);
      checkOutput("wrap.preCount", 32'(COUNT), 32'd2);
      for (int k = 0; k < 6; k++) begin
         logic [W-1:0] d;
         d = 8'hA0 + W'(k);
         expQ.push_back(d);
         applyStimulus(1'b1, 1'b1, 1'b1, d);
         checkOutput($sformatf("wrap.O%0d", k), 32'(O), 32'(expQ.pop_front()));
         checkOutput($sformatf("wrap.vld%0d", k), 32'(O_VALID), 32'd1);
         checkOutput($sformatf("wrap.cnt%0d", k), 32'(COUNT), 32'd2);
      end
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
         checkOutput($sformatf("drain.O%0d", k), 32'(O), 32'(expQ.pop_front()));
      end
      checkOutput("drain.EMPTY", 32'(EMPTY), 32'd1);
      lastO = O;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("drain.holdO", 32'(O), 32'(lastO));
      checkOutput("drain.idleVld", 32'(O_VALID), 32'd0);

      // Reset with three bytes stored and both enables high; afterwards a
      // write into the empty FIFO with a read request must store the byte,
      // refuse the read and set UNF, and only the new byte comes out.
      $display("[TB] mid-operation reset");
      applyStimulus(1'b1, 1'b1, 1'b0, 8'hC0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'hC1);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'hC2);
      checkOutput("rst.preCount", 32'(COUNT), 32'd3);
      applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE);
      checkAll("rst", 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'hD0);
      checkAll("wrEmpty", 8'h00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
      checkAll("newData", 8'hD0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("newData.pulse", 32'(O_VALID), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
